ram_fifo_ctrl: RTL

FIFO controller that drives a single-port synchronous RAM (one access per cycle, registered read data with one cycle of latency, write-enable port) and presents it as a valid/ready streaming FIFO. It sits directly upstream of the RAM instance and drives its `we`, `address` and `data_in`. It consumes the RAM's `data_out` and buffers it into a registered output slot. Reads and writes share the single RAM port and are arbitrated every cycle.

---
 rtl/ram_fifo_ctrl_if.sv | 46 ++++
 rtl/ram_fifo_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - stream and RAM-port bundle for ram_fifo_ctrl
// slave is the controller's view; master is the surrounding producer/consumer/RAM.
interface ram_fifo_ctrl_if #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 8
);
   logic [D_WIDTH-1:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic [D_WIDTH-1:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic [A_WIDTH:0]   count;
   logic               ram_we;
   logic [A_WIDTH-1:0] ram_address;
   logic [D_WIDTH-1:0] ram_data_in;
   logic [D_WIDTH-1:0] ram_data_out;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready,
      output count,
      output ram_we,
      output ram_address,
      output ram_data_in,
      input  ram_data_out
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  count,
      input  ram_we,
      input  ram_address,
      input  ram_data_in,
      output ram_data_out
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready FIFO over a single-port synchronous RAM
// Reads win the shared port; read data lands one cycle later into a registered output slot.
module ram_fifo_ctrl #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ram_fifo_ctrl_if.slave       bus
);
   localparam logic [A_WIDTH:0] FULL_LEVEL = {1'b1, {A_WIDTH{1'b0}}};

   logic [A_WIDTH-1:0] wr_ptr;
   logic [A_WIDTH-1:0] rd_ptr;
   logic [A_WIDTH:0]   mem_count;
   logic               read_pending;
   logic               out_valid_q;
   logic [D_WIDTH-1:0] out_data_q;

   logic rd_req;
   logic mem_empty;
   logic mem_full;
   logic in_ready_c;
   logic push;
   logic pop;

   assign mem_empty = (mem_count == '0);
   assign mem_full  = (mem_count == FULL_LEVEL);

   // A read may only be issued when the slot will be free by the time the data lands.
   assign rd_req = !mem_empty && !read_pending && (!out_valid_q || bus.out_ready);

   assign in_ready_c = reset_n && !rd_req && !mem_full;
   assign push       = bus.in_valid && in_ready_c;
   assign pop        = out_valid_q && bus.out_ready;

   assign bus.in_ready    = in_ready_c;
   assign bus.ram_we      = push;
   assign bus.ram_address = push ? wr_ptr : rd_ptr;
   assign bus.ram_data_in = bus.in_data;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.count       = mem_count
                          + (A_WIDTH+1)'(read_pending)
                          + (A_WIDTH+1)'(out_valid_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
      end else if (rd_req) begin
         rd_ptr    <= rd_ptr + A_WIDTH'(1);
         mem_count <= mem_count - (A_WIDTH+1)'(1);
      end else if (push) begin
         wr_ptr    <= wr_ptr + A_WIDTH'(1);
         mem_count <= mem_count + (A_WIDTH+1)'(1);
      end
   end

   // A landing read takes precedence over a pop, so the slot stays valid across the handoff.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         read_pending <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         read_pending <= rd_req;
         if (read_pending) begin
            out_data_q  <= bus.ram_data_out;
            out_valid_q <= 1'b1;
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule
